// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter states and the minimum
// bit-period divisor, reused by the transmitter and the future receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  localparam int UART_MIN_DIV = 2;

  // Even parity is the plain XOR of the data bits; odd parity is its inverse.
  function automatic logic parity_bit(parity_t mode, logic data_xor);
    return (mode == PAR_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/uart_tx_cfg_baud_tick.sv
// Loadable bit-period down-counter; strobes o_bit_end on the last cycle of
// every bit. The divisor is sampled only when i_load restarts the count.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_bit_end
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_reload;
  logic [DIV_W-1:0] w_eff_m1;

  // Divisors below the minimum are clamped so every bit spans at least two cycles.
  assign w_eff_m1 = (i_div < DIV_W'(UART_MIN_DIV)) ? DIV_W'(UART_MIN_DIV - 1)
                                                   : i_div - DIV_W'(1);

  assign o_bit_end = i_en && (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_reload <= '0;
    end else if (i_load) begin
      r_cnt    <= w_eff_m1;
      r_reload <= w_eff_m1;
    end else if (i_en) begin
      if (r_cnt == '0) begin
        r_cnt <= r_reload;
      end else begin
        r_cnt <= r_cnt - DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with a single-entry AXI-Stream holding register; frames are
// sent LSB-first and queued words follow each other with no idle gap.
module uart_tx_cfg #(
  parameter int DATA_W    = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DIV_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic              tx_data,
  output logic              tx_busy,
  output logic              tx_done
);
  import uart_pkg::*;

  localparam parity_t PAR_MODE = parity_t'(2'(PARITY));
  localparam int      IDX_W    = $clog2(DATA_W);

  uart_tx_state_t    r_state;
  logic [DATA_W-1:0] r_hold;
  logic              r_hold_full;
  logic              r_ready;
  logic [DATA_W-1:0] r_shift;
  logic [IDX_W-1:0]  r_idx;
  logic              r_stop_cnt;
  logic              r_par;
  logic              r_tx;
  logic              r_done;

  logic w_accept;
  logic w_bit_end;
  logic w_last_stop;
  logic w_load;
  logic w_en;

  assign w_accept    = s_axis_tvalid && r_ready;
  assign w_last_stop = (r_stop_cnt == 1'(STOP_BITS - 1));
  assign w_en        = (r_state != IDLE);
  assign w_load      = r_hold_full &&
                       ((r_state == IDLE) ||
                        ((r_state == STOP) && w_bit_end && w_last_stop));

  uart_baud_tick #(
    .DIV_W (DIV_W)
  ) u_tick (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_en      (w_en),
    .i_div     (baud_div),
    .o_bit_end (w_bit_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_ready     <= 1'b1;
      r_shift     <= '0;
      r_idx       <= '0;
      r_stop_cnt  <= 1'b0;
      r_par       <= 1'b0;
      r_tx        <= 1'b1;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;

      // tready is low whenever the hold is full, so a fill and a load never collide.
      if (w_accept) begin
        r_hold      <= s_axis_tdata;
        r_hold_full <= 1'b1;
        r_ready     <= 1'b0;
      end else if (w_load) begin
        r_hold_full <= 1'b0;
        r_ready     <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          r_tx <= 1'b1;
        end
        START: begin
          if (w_bit_end) begin
            r_state <= DATA;
            r_idx   <= '0;
            r_tx    <= r_shift[0];
          end
        end
        DATA: begin
          if (w_bit_end) begin
            if (r_idx == IDX_W'(DATA_W - 1)) begin
              if (PAR_MODE != PAR_NONE) begin
                r_state <= uart_pkg::PARITY;
                r_tx    <= r_par;
              end else begin
                r_state    <= STOP;
                r_stop_cnt <= 1'b0;
                r_tx       <= 1'b1;
              end
            end else begin
              r_idx   <= r_idx + IDX_W'(1);
              r_shift <= r_shift >> 1;
              r_tx    <= r_shift[1];
            end
          end
        end
        uart_pkg::PARITY: begin
          if (w_bit_end) begin
            r_state    <= STOP;
            r_stop_cnt <= 1'b0;
            r_tx       <= 1'b1;
          end
        end
        STOP: begin
          if (w_bit_end) begin
            if (w_last_stop) begin
              r_done  <= 1'b1;
              r_state <= IDLE;
              r_tx    <= 1'b1;
            end else begin
              r_stop_cnt <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= 1'b1;
        end
      endcase

      // A frame load overrides the case above, both from IDLE and from the last stop bit.
      if (w_load) begin
        r_shift <= r_hold;
        r_par   <= parity_bit(PAR_MODE, ^r_hold);
        r_state <= START;
        r_tx    <= 1'b0;
      end
    end
  end

  assign s_axis_tready = r_ready;
  assign tx_data       = r_tx;
  assign tx_done       = r_done;
  assign tx_busy       = (r_state != IDLE) || r_hold_full;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: three configurations (8E1, 7O2, 8N1) checked every
// cycle against a frame-waveform model, plus literal frame and timing checks.
module tb_uart_tx_cfg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] bdA, bdB, bdC;
  logic [7:0]  tdA, tdC;
  logic [6:0]  tdB;
  logic        tvA, tvB, tvC;
  logic        rdyA, txA, busyA, doneA;
  logic        rdyB, txB, busyB, doneB;
  logic        rdyC, txC, busyC, doneC;

  uart_tx_cfg #(.DATA_W(8), .PARITY(2), .STOP_BITS(1), .DIV_W(16)) u_a (
    .clk(clk), .rst(rst), .baud_div(bdA), .s_axis_tdata(tdA), .s_axis_tvalid(tvA),
    .s_axis_tready(rdyA), .tx_data(txA), .tx_busy(busyA), .tx_done(doneA));

  uart_tx_cfg #(.DATA_W(7), .PARITY(1), .STOP_BITS(2), .DIV_W(16)) u_b (
    .clk(clk), .rst(rst), .baud_div(bdB), .s_axis_tdata(tdB), .s_axis_tvalid(tvB),
    .s_axis_tready(rdyB), .tx_data(txB), .tx_busy(busyB), .tx_done(doneB));

  uart_tx_cfg #(.DATA_W(8), .PARITY(0), .STOP_BITS(1), .DIV_W(16)) u_c (
    .clk(clk), .rst(rst), .baud_div(bdC), .s_axis_tdata(tdC), .s_axis_tvalid(tvC),
    .s_axis_tready(rdyC), .tx_data(txC), .tx_busy(busyC), .tx_done(doneC));

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int dA[$], dB[$], dC[$];

  // Model: the current frame as a bit vector, its divisor, and the cycle position in it.
  logic [15:0] m_bits[3];
  int          m_div[3], m_pos[3], m_len[3];
  logic        m_full[3], m_done[3];
  logic [8:0]  m_hold[3];
  logic        m_en = 1'b0;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic int cfg_dw(int i);  return (i == 1) ? 7 : 8; endfunction
  function automatic int cfg_par(int i); return (i == 0) ? 2 : ((i == 1) ? 1 : 0); endfunction
  function automatic int cfg_sb(int i);  return (i == 1) ? 2 : 1; endfunction

  function automatic logic get_tv(int i);
    return (i == 0) ? tvA : ((i == 1) ? tvB : tvC);
  endfunction
  function automatic logic [8:0] get_td(int i);
    return (i == 0) ? {1'b0, tdA} : ((i == 1) ? {2'b0, tdB} : {1'b0, tdC});
  endfunction
  function automatic int get_bd(int i);
    return (i == 0) ? int'(bdA) : ((i == 1) ? int'(bdB) : int'(bdC));
  endfunction
  function automatic logic get_tx(int i);
    return (i == 0) ? txA : ((i == 1) ? txB : txC);
  endfunction
  function automatic logic get_done(int i);
    return (i == 0) ? doneA : ((i == 1) ? doneB : doneC);
  endfunction
  function automatic logic get_busy(int i);
    return (i == 0) ? busyA : ((i == 1) ? busyB : busyC);
  endfunction
  function automatic logic get_rdy(int i);
    return (i == 0) ? rdyA : ((i == 1) ? rdyB : rdyC);
  endfunction

  task automatic build_frame(int i);
    int   d, dw, par, nb;
    logic x;
    logic [15:0] bits;
    d    = (get_bd(i) < 2) ? 2 : get_bd(i);
    dw   = cfg_dw(i);
    par  = cfg_par(i);
    bits = '1;
    bits[0] = 1'b0;
    x = 1'b0;
    for (int k = 0; k < dw; k++) begin
      bits[1 + k] = m_hold[i][k];
      x = x ^ m_hold[i][k];
    end
    if (par != 0) bits[1 + dw] = (par == 2) ? x : ~x;
    nb = 1 + dw + ((par != 0) ? 1 : 0) + cfg_sb(i);
    m_bits[i] = bits;
    m_div[i]  = d;
    m_len[i]  = nb * d;
    m_pos[i]  = 0;
  endtask

  task automatic model_step(int i);
    logic ending, load, acc;
    if (rst) begin
      m_len[i]  = 0;
      m_pos[i]  = 0;
      m_full[i] = 1'b0;
      m_done[i] = 1'b0;
    end else begin
      ending = (m_len[i] != 0) && (m_pos[i] == m_len[i] - 1);
      acc    = get_tv(i) && !m_full[i];
      load   = m_full[i] && ((m_len[i] == 0) || ending);
      if (m_len[i] != 0) m_pos[i]++;
      if (ending) m_len[i] = 0;
      m_done[i] = ending;
      if (load) begin
        build_frame(i);
        m_full[i] = 1'b0;
      end
      if (acc) begin
        m_full[i] = 1'b1;
        m_hold[i] = get_td(i);
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 3; i++) model_step(i);
    if (rst) m_en = 1'b1;
  end

  // Single compare process: every cycle, every instance, all four outputs.
  initial forever begin
    @(negedge clk);
    if (doneA) dA.push_back(cyc);
    if (doneB) dB.push_back(cyc);
    if (doneC) dC.push_back(cyc);
    if (m_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("tx_data[%0d]", i), 32'(get_tx(i)),
            32'((m_len[i] != 0) ? m_bits[i][m_pos[i] / m_div[i]] : 1'b1));
        chk($sformatf("tx_done[%0d]", i), 32'(get_done(i)), 32'(m_done[i]));
        chk($sformatf("tx_busy[%0d]", i), 32'(get_busy(i)),
            32'((m_len[i] != 0) || m_full[i]));
        chk($sformatf("tready[%0d]", i), 32'(get_rdy(i)), 32'(!m_full[i]));
      end
    end
  end

  task automatic set_in(int i, logic v, logic [8:0] d);
    case (i)
      0: begin tvA = v; tdA = d[7:0]; end
      1: begin tvB = v; tdB = d[6:0]; end
      default: begin tvC = v; tdC = d[7:0]; end
    endcase
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(int i, logic [8:0] d);
    int n;
    set_in(i, 1'b1, d);
    n = 0;
    while (!get_rdy(i) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("send_timeout", 32'd0, 32'd1);
    @(negedge clk);
    set_in(i, 1'b0, d);
  endtask

  task automatic wait_idle(int i);
    int n;
    n = 0;
    while (get_busy(i) !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  // Samples each bit mid-period from the start-bit fall and checks tx_done timing.
  task automatic frame_check(int i, int div, int nb, logic [15:0] exp, string nm);
    int n, early, len;
    logic [15:0] got;
    n = 0;
    while (get_tx(i) !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk({nm, "_fall_timeout"}, 32'd0, 32'd1);
    got   = '0;
    early = 0;
    len   = nb * div;
    got[0] = get_tx(i);
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      if (c < len) begin
        if (get_done(i)) early++;
        if (c % div == 1) got[c / div] = get_tx(i);
      end
    end
    chk({nm, "_bits"}, 32'(got), 32'(exp));
    chk({nm, "_done_at_end"}, 32'(get_done(i)), 32'd1);
    chk({nm, "_done_early"}, 32'(early), 32'd0);
  endtask

  initial begin
    int n0, bad;
    rst = 1'b1;
    tvA = 1'b0; tvB = 1'b0; tvC = 1'b0;
    tdA = '0; tdB = '0; tdC = '0;
    bdA = 16'd4; bdB = 16'd3; bdC = 16'd2;
    repeat (3) @(negedge clk);
    chk("reset_tx", 32'({txA, txB, txC}), 32'h7);
    chk("reset_busy", 32'({busyA, busyB, busyC}), 32'h0);
    chk("reset_done", 32'({doneA, doneB, doneC}), 32'h0);
    chk("reset_tready", 32'({rdyA, rdyB, rdyC}), 32'h7);
    rst = 1'b0;
    @(negedge clk);

    // 8E1, div 4, 0xA5: 0, 1,0,1,0,0,1,0,1, parity 0, stop 1
    send(0, 9'h0A5);
    frame_check(0, 4, 11, 16'h054A, "A_8E1");
    wait_idle(0);

    // 7O2, div 3, 0x00: start, seven zeros, parity 1, two stops
    n0 = dB.size();
    send(1, 9'h000);
    frame_check(1, 3, 11, 16'h0700, "B_7O2");
    repeat (20) @(negedge clk);
    chk("B_done_count", 32'(dB.size() - n0), 32'd1);

    // 8N1, div 2, three words with tvalid held high
    n0 = dC.size();
    send(2, 9'h011);
    send(2, 9'h022);
    chk("C_tready_hold_full", 32'(rdyC), 32'd0);
    chk("C_busy_hold_full", 32'(busyC), 32'd1);
    send(2, 9'h033);
    wait_idle(2);
    chk("C_done_count", 32'(dC.size() - n0), 32'd3);
    if (dC.size() - n0 == 3) begin
      chk("C_gap_1", 32'(dC[n0 + 1] - dC[n0]), 32'd20);
      chk("C_gap_2", 32'(dC[n0 + 2] - dC[n0 + 1]), 32'd20);
    end

    // Divisors 0 and 1 both give two cycles per bit
    for (int v = 0; v < 2; v++) begin
      bdC = 16'(v);
      n0 = dC.size();
      send(2, 9'h05A);
      send(2, 9'h0C3);
      wait_idle(2);
      chk($sformatf("C_div%0d_count", v), 32'(dC.size() - n0), 32'd2);
      if (dC.size() - n0 == 2) chk($sformatf("C_div%0d_gap", v), 32'(dC[n0 + 1] - dC[n0]), 32'd20);
    end

    // Divisor change mid-frame applies only from the next frame
    bdC = 16'd4;
    n0 = dC.size();
    send(2, 9'h055);
    send(2, 9'h0AA);
    repeat (5) @(negedge clk);
    bdC = 16'd8;
    wait_idle(2);
    chk("C_divchg_count", 32'(dC.size() - n0), 32'd2);
    if (dC.size() - n0 == 2) chk("C_divchg_gap", 32'(dC[n0 + 1] - dC[n0]), 32'd80);

    // Reset during data bit 3 with a second word held
    bdA = 16'd4;
    send(0, 9'h03C);
    send(0, 9'h0C3);
    repeat (15) @(negedge clk);
    chk("A_pre_reset_busy", 32'(busyA), 32'd1);
    rst = 1'b1;
    n0 = dA.size();
    @(negedge clk);
    chk("A_reset_tx", 32'(txA), 32'd1);
    chk("A_reset_busy", 32'(busyA), 32'd0);
    chk("A_reset_tready", 32'(rdyA), 32'd1);
    chk("A_reset_done", 32'(doneA), 32'd0);
    rst = 1'b0;

    // Idle line for 100 cycles with no valid words
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (txA !== 1'b1 || busyA !== 1'b0 || txC !== 1'b1 || busyC !== 1'b0) bad++;
    end
    chk("idle_line_bad_cycles", 32'(bad), 32'd0);
    chk("A_no_done_after_reset", 32'(dA.size() - n0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
